// File: rtl/mem_fabric.sv
// Fixed-priority memory-bus fabric: sequences 1..4 byte little-endian transfers from
// NUM_PORTS masters onto one 8-bit RAM/IO bus with region decode and IO write back-pressure.
module mem_fabric #(
  parameter int unsigned RAM_ADDR_WIDTH = 17,
  parameter int unsigned NUM_PORTS      = 2,
  parameter int unsigned LEN_W          = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic [NUM_PORTS-1:0]         req_valid,
  input  logic [NUM_PORTS-1:0]         req_wr,
  input  logic [32*NUM_PORTS-1:0]      req_addr,
  input  logic [LEN_W*NUM_PORTS-1:0]   req_len,
  input  logic [32*NUM_PORTS-1:0]      req_wdata,
  output logic [NUM_PORTS-1:0]         done,
  output logic [31:0]                  rdata,
  output logic                         busy,
  output logic [31:0]                  mem_a,
  output logic                         mem_wr,
  output logic [7:0]                   mem_dout,
  input  logic [7:0]                   mem_din,
  input  logic [7:0]                   io_din,
  input  logic                         io_full,
  output logic                         ram_en,
  output logic                         io_en
);

  localparam int unsigned PortW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  function automatic logic is_io(input logic [31:0] a);
    return a[RAM_ADDR_WIDTH -: 2] == 2'b11;
  endfunction

  state_e               state_q, state_d;
  logic [PortW-1:0]     port_q, port_d;
  logic [31:0]          addr_q, addr_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic                 wr_q, wr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [31:0]          rbuf_q, rbuf_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [NUM_PORTS-1:0] done_q, done_d;
  logic                 cap_vld_q, cap_vld_d;
  logic [LEN_W-1:0]     cap_idx_q, cap_idx_d;
  logic                 cap_io_q, cap_io_d;
  logic                 frozen_q, frozen_d;
  logic [31:0]          mem_a_q, mem_a_d;
  logic [7:0]           mem_dout_q, mem_dout_d;

  logic [31:0] cur_addr, iss_addr;
  logic        reissue, iss_io, stall, active, found;

  // A read byte whose return slot was frozen over is fetched again on the first live cycle.
  always_comb begin
    cur_addr = addr_q + 32'(cnt_q);
    reissue  = rdy_in && frozen_q && cap_vld_q;
    iss_addr = reissue ? addr_q + 32'(cap_idx_q) : cur_addr;
    iss_io   = is_io(iss_addr);
    stall    = wr_q && iss_io && io_full && !reissue;
    active   = rdy_in && ((state_q == StIssue && !stall) || reissue);
    mem_a    = (state_q == StIssue || reissue) ? iss_addr : mem_a_q;
    mem_wr   = active && wr_q;
    ram_en   = active && !iss_io;
    io_en    = active && iss_io;
    mem_dout = (state_q == StIssue && wr_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : mem_dout_q;
    busy     = state_q != StIdle;
    done     = done_q;
    rdata    = rdata_q;
  end

  always_comb begin
    state_d    = state_q;
    port_d     = port_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rbuf_d     = rbuf_q;
    rdata_d    = rdata_q;
    done_d     = done_q;
    cap_vld_d  = cap_vld_q;
    cap_idx_d  = cap_idx_q;
    cap_io_d   = cap_io_q;
    frozen_d   = !rdy_in;
    mem_a_d    = mem_a;
    mem_dout_d = mem_dout;
    found      = 1'b0;
    if (rdy_in) begin
      cap_vld_d = active && !wr_q;
      cap_idx_d = reissue ? cap_idx_q : cnt_q;
      cap_io_d  = iss_io;
      if (cap_vld_q && !reissue) begin
        rbuf_d[{cap_idx_q, 3'b000} +: 8] = cap_io_q ? io_din : mem_din;
      end
      done_d = '0;
      unique case (state_q)
        StIdle: begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (req_valid[p] && !found) begin
              found   = 1'b1;
              port_d  = PortW'(p);
              addr_d  = req_addr[32*p +: 32];
              wr_d    = req_wr[p];
              wdata_d = req_wdata[32*p +: 32];
              len_d   = is_io(req_addr[32*p +: 32]) ? '0 : req_len[LEN_W*p +: LEN_W];
              cnt_d   = '0;
              rbuf_d  = '0;
              state_d = StIssue;
            end
          end
        end
        StIssue: begin
          if (!reissue && !stall) begin
            cnt_d = cnt_q + LEN_W'(1);
            if (cnt_q == len_q) state_d = wr_q ? StDone : StDrain;
          end
        end
        StDrain: begin
          if (!reissue) begin
            rdata_d = rbuf_d;
            state_d = StDone;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
      if (state_d == StDone) done_d[port_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      port_q     <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rbuf_q     <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
      cap_vld_q  <= 1'b0;
      cap_idx_q  <= '0;
      cap_io_q   <= 1'b0;
      frozen_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rbuf_q     <= rbuf_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      cap_vld_q  <= cap_vld_d;
      cap_idx_q  <= cap_idx_d;
      cap_io_q   <= cap_io_d;
      frozen_q   <= frozen_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
    end
  end

endmodule

// File: tb/tb_mem_fabric.sv
// Directed and randomized bench for mem_fabric against a byte-array reference model.
module tb_mem_fabric;

  localparam int NP = 2;

  logic            clk_in = 1'b0;
  logic            rst_in, rdy_in;
  logic [NP-1:0]   req_valid, req_wr;
  logic [32*NP-1:0] req_addr, req_wdata;
  logic [2*NP-1:0] req_len;
  logic [NP-1:0]   done;
  logic [31:0]     rdata, mem_a;
  logic            busy, mem_wr, io_full, ram_en, io_en;
  logic [7:0]      mem_dout;
  logic [7:0]      mem_din = 8'h00;
  logic [7:0]      io_din = 8'h00;

  logic [7:0] ram     [0:131071];
  logic [7:0] ref_mem [0:131071];
  logic [7:0] io_src;
  logic [7:0] io_log [$];

  int checks = 0;
  int failures = 0;

  mem_fabric #(.RAM_ADDR_WIDTH(17), .NUM_PORTS(NP), .LEN_W(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
    .req_wdata(req_wdata), .done(done), .rdata(rdata), .busy(busy), .mem_a(mem_a),
    .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din), .io_din(io_din),
    .io_full(io_full), .ram_en(ram_en), .io_en(io_en)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous RAM and IO device models.
  always @(posedge clk_in) begin
    if (ram_en) begin
      if (mem_wr) ram[mem_a[16:0]] <= mem_dout;
      else        mem_din <= ram[mem_a[16:0]];
    end
    if (io_en) begin
      if (mem_wr) io_log.push_back(mem_dout);
      else        io_din <= io_src;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input bit v, input bit wr, input logic [31:0] a,
                         input logic [1:0] len, input logic [31:0] wd);
    req_valid[p]         = v;
    req_wr[p]            = wr;
    req_addr[32*p +: 32] = a;
    req_len[2*p +: 2]    = len;
    req_wdata[32*p +: 32] = wd;
  endtask

  // One transfer from an idle fabric; full = cycles io_full stays high after grant.
  task automatic xfer(input int p, input bit wr, input logic [31:0] a, input int len,
                      input logic [31:0] wd, input int full);
    bit          io;
    int          n, lat, k, iss, log0;
    bit          got;
    logic [31:0] exp_rd;
    io     = (a[17:16] == 2'b11);
    n      = io ? 1 : len + 1;
    lat    = wr ? n + 1 + ((io && full > 0) ? full : 0) : n + 2;
    exp_rd = '0;
    for (int b = 0; b < n; b++) exp_rd[8*b +: 8] = io ? io_src : ref_mem[17'(a + 32'(b))];
    log0 = io_log.size();
    @(posedge clk_in); #1;
    set_req(p, 1'b1, wr, a, 2'(len), wd);
    io_full = (full > 0);
    k = 0; iss = 0; got = 0;
    while (!got && k < 60) begin
      @(posedge clk_in); #1;
      k++;
      if (k > full) io_full = 1'b0;
      @(negedge clk_in);
      if (ram_en || io_en) begin
        chk("iss_addr", mem_a, a + 32'(iss));
        chk("iss_wr", 32'(mem_wr), 32'(wr));
        chk("iss_io_en", 32'(io_en), 32'(io));
        chk("iss_ram_en", 32'(ram_en), 32'(!io));
        if (wr && iss < 4) chk("iss_dout", 32'(mem_dout), 32'(wd[8*iss +: 8]));
        iss++;
      end
      if (done != '0) begin
        got = 1;
        chk("done_port", 32'(done), 32'(1 << p));
        chk("done_latency", k, lat);
        if (!wr) chk("rdata", rdata, exp_rd);
      end
    end
    if (!got) chk("done_timeout", 32'(0), 32'(1));
    chk("iss_count", iss, n);
    set_req(p, 1'b0, 1'b0, '0, '0, '0);
    io_full = 1'b0;
    if (wr && !io) for (int b = 0; b < n; b++) ref_mem[17'(a + 32'(b))] = wd[8*b +: 8];
    if (wr && io) begin
      chk("io_log_len", io_log.size(), log0 + 1);
      if (io_log.size() > 0) chk("io_byte", 32'(io_log[$]), 32'(wd[7:0]));
    end
  endtask

  initial begin
    int          k, nstr, fstr, d0, d1, dseen;
    logic [31:0] exp_rd;
    logic [31:0] seq [$];
    bit          io, wr;
    logic [31:0] a;
    int          len, full;

    rst_in = 1'b0; rdy_in = 1'b1; io_full = 1'b0; io_src = 8'h00;
    req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    for (int i = 0; i < 131072; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    for (int i = 32'h100; i < 32'h104; i++) ref_mem[i] = ram[i];

    #2 rst_in = 1'b1;
    #1;
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("rst_mem_dout", 32'(mem_dout), 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_io_en", 32'(io_en), 32'h0);
    @(posedge clk_in); @(posedge clk_in); #1 rst_in = 1'b0;

    xfer(1, 1'b0, 32'h100, 3, 32'h0, 0);
    chk("tp_rdata_le", rdata, 32'h44332211);
    xfer(1, 1'b1, 32'h1FFFE, 1, 32'h0000BEEF, 0);
    chk("tp_ram_fffe", 32'(ram[17'h1FFFE]), 32'hEF);
    chk("tp_ram_ffff", 32'(ram[17'h1FFFF]), 32'hBE);
    xfer(1, 1'b1, 32'h30000, 3, 32'hCAFE0077, 5);
    io_src = 8'h5A;
    xfer(0, 1'b0, 32'h30004, 2, 32'h0, 0);
    chk("tp_io_rdata", rdata, 32'h0000005A);
    io_src = 8'hA5;
    xfer(0, 1'b0, 32'h200, 0, 32'h0, 0);
    chk("tp_ram_after_io", rdata, {24'h0, ref_mem[32'h200]});

    // Simultaneous requests: port 0 write wins, port 1 read follows after one idle cycle.
    exp_rd = {24'h0, ref_mem[32'h600]};
    @(posedge clk_in); #1;
    set_req(0, 1'b1, 1'b1, 32'h500, 2'd1, 32'h00009A8B);
    set_req(1, 1'b1, 1'b0, 32'h600, 2'd0, 32'h0);
    k = 0; d0 = 0; d1 = 0; dseen = 0;
    seq.delete();
    while (d1 == 0 && k < 40) begin
      @(posedge clk_in); #1;
      k++;
      @(negedge clk_in);
      if (ram_en || io_en) seq.push_back(mem_a);
      if (done == 2'b11) dseen++;
      if (done[0]) begin d0 = k; set_req(0, 1'b0, 1'b0, '0, '0, '0); end
      if (done[1]) begin d1 = k; set_req(1, 1'b0, 1'b0, '0, '0, '0); end
    end
    ref_mem[32'h500] = 8'h8B; ref_mem[32'h501] = 8'h9A;
    chk("prio_done0_cycle", d0, 3);
    chk("prio_done1_cycle", d1, 7);
    chk("prio_done_overlap", dseen, 0);
    chk("prio_seq_len", seq.size(), 3);
    if (seq.size() == 3) begin
      chk("prio_seq0", seq[0], 32'h500);
      chk("prio_seq1", seq[1], 32'h501);
      chk("prio_seq2", seq[2], 32'h600);
    end
    chk("prio_rdata", rdata, exp_rd);

    // Freeze for three cycles while the first read byte is in flight.
    for (int b = 0; b < 4; b++) exp_rd[8*b +: 8] = ref_mem[32'h400 + b];
    @(posedge clk_in); #1;
    set_req(0, 1'b1, 1'b0, 32'h400, 2'd3, 32'h0);
    k = 0; nstr = 0; fstr = 0; d0 = 0;
    while (d0 == 0 && k < 40) begin
      @(posedge clk_in); #1;
      k++;
      rdy_in = !(k >= 2 && k <= 4);
      @(negedge clk_in);
      if (ram_en || io_en || mem_wr) begin
        if (!rdy_in) fstr++;
        else nstr++;
        if (k == 5) chk("frz_reissue_addr", mem_a, 32'h400);
      end
      if (done[0]) d0 = k;
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    rdy_in = 1'b1;
    chk("frz_latency", d0, 10);
    chk("frz_strobes_frozen", fstr, 0);
    chk("frz_strobes", nstr, 5);
    chk("frz_rdata", rdata, exp_rd);

    // Reset after two bytes of a four-byte write.
    @(posedge clk_in); #1;
    set_req(1, 1'b1, 1'b1, 32'h800, 2'd3, 32'hA1B2C3D4);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk_in); #1;
    end
    rst_in = 1'b1;
    #1;
    chk("mid_rst_mem_wr", 32'(mem_wr), 32'h0);
    chk("mid_rst_ram_en", 32'(ram_en), 32'h0);
    chk("mid_rst_mem_a", mem_a, 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    @(posedge clk_in); #1 rst_in = 1'b0;
    dseen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      if (done != '0) dseen++;
    end
    chk("mid_rst_no_done", dseen, 0);
    ref_mem[32'h800] = 8'hD4; ref_mem[32'h801] = 8'hC3;
    xfer(0, 1'b0, 32'h800, 3, 32'h0, 0);

    for (int t = 0; t < 40; t++) begin
      io   = ($urandom_range(0, 7) == 0);
      wr   = 1'($urandom_range(0, 1));
      a    = io ? (32'h30000 | 32'($urandom_range(0, 255))) : 32'($urandom_range(0, 32'h2FFF0));
      len  = $urandom_range(0, 3);
      full = (io && wr) ? $urandom_range(0, 3) : 0;
      io_src = 8'($urandom);
      xfer($urandom_range(0, 1), wr, a, len, $urandom, full);
    end

    @(negedge clk_in);
    chk("final_idle", 32'(busy), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
